// File: rtl/frac_search.sv
// Quarter-pel fractional motion refinement for one 8x8 block: bilinear candidates, per-candidate SAD, best (mvx, mvy).
// Define FRAC_SEARCH_HALF_PEL_ONLY_EN to evaluate only the 9 half-pel candidates (dx, dy in {0,2,4}).
//
// state  | meaning
// S_IDLE | accumulating rows, no result pending
// S_CMP  | block finished last edge; minimum SAD is latched into mvx/mvy this edge
module frac_search #(
    parameter int SAD_W = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] filter_pix,
    input  logic [63:0] ref_pix,
    input  logic        input_ready,
    output logic [2:0]  mvx,
    output logic [2:0]  mvy
);

`ifdef FRAC_SEARCH_HALF_PEL_ONLY_EN
    localparam int STEP = 2;
    localparam int NDIM = 3;
`else
    localparam int STEP = 1;
    localparam int NDIM = 5;
`endif
    localparam int NC = NDIM * NDIM;

    typedef enum logic {S_IDLE, S_CMP} state_t;

    state_t              state, state_nx;
    logic                cmp_en;
    logic [2:0]          row_cnt;
    logic [63:0]         f_prev;
    logic [63:0]         r_prev;
    logic [NC*SAD_W-1:0] acc_flat;
    logic [SAD_W-1:0]    best_sad;
    logic [2:0]          best_x;
    logic [2:0]          best_y;
    logic                accept;
    logic                first_row;

    assign accept    = input_ready;
    assign first_row = (row_cnt == 3'd0);

    // Weights are constant per candidate, so each product reduces to a shift/add network.
    function automatic logic [7:0] interp(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d,
                                          input int dx, input int dy);
        int sum;
        sum = (4 - dx) * (4 - dy) * int'(a) + dx * (4 - dy) * int'(b)
            + (4 - dx) * dy * int'(c) + dx * dy * int'(d) + 8;
        return 8'(sum >> 4);
    endfunction

    function automatic logic [10:0] row_cost(input logic [63:0] f, input logic [63:0] r0,
                                             input logic [63:0] r1, input int dx, input int dy);
        logic [10:0] s;
        logic [7:0]  p;
        logic [7:0]  fv;
        s = '0;
        for (int i = 0; i < 7; i++) begin
            p  = interp(r0[8*i +: 8], r0[8*i+8 +: 8], r1[8*i +: 8], r1[8*i+8 +: 8], dx, dy);
            fv = f[8*i +: 8];
            s  = s + 11'((fv > p) ? (fv - p) : (p - fv));
        end
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
            f_prev  <= '0;
            r_prev  <= '0;
        end else if (accept) begin
            row_cnt <= row_cnt + 3'd1;
            f_prev  <= filter_pix;
            r_prev  <= ref_pix;
        end
    end

    for (genvar gy = 0; gy < NDIM; gy++) begin : g_y
        for (genvar gx = 0; gx < NDIM; gx++) begin : g_x
            localparam int IDX = gy * NDIM + gx;
            logic [10:0]      sad_row;
            logic [SAD_W-1:0] acc;

            assign sad_row = row_cost(f_prev, r_prev, ref_pix, gx * STEP, gy * STEP);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc <= '0;
                end else if (accept) begin
                    if (first_row) acc <= '0;
                    else           acc <= acc + SAD_W'(sad_row);
                end
            end

            assign acc_flat[IDX*SAD_W +: SAD_W] = acc;
        end
    end

    // Scan dy outer, dx inner; strict less-than keeps the earliest candidate on ties.
    always_comb begin
        best_sad = acc_flat[SAD_W-1:0];
        best_x   = '0;
        best_y   = '0;
        for (int y = 0; y < NDIM; y++) begin
            for (int x = 0; x < NDIM; x++) begin
                if (acc_flat[(y*NDIM+x)*SAD_W +: SAD_W] < best_sad) begin
                    best_sad = acc_flat[(y*NDIM+x)*SAD_W +: SAD_W];
                    best_x   = 3'(x * STEP);
                    best_y   = 3'(y * STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = S_IDLE;
        if (accept && row_cnt == 3'd7) state_nx = S_CMP;
    end

    always_comb begin
        cmp_en = (state == S_CMP);
    end

    // The compare edge reads the finished SADs before a same-edge row-0 clear takes effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mvx <= '0;
            mvy <= '0;
        end else if (cmp_en) begin
            mvx <= best_x;
            mvy <= best_y;
        end
    end

endmodule

// File: tb/tb_frac_search.sv
// Scoreboard bench for frac_search: reference SAD search over whole blocks, monitor checks mvx/mvy every cycle.
module tb_frac_search;

`ifdef FRAC_SEARCH_HALF_PEL_ONLY_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] filter_pix;
    logic [63:0] ref_pix;
    logic        input_ready;
    logic [2:0]  mvx;
    logic [2:0]  mvy;

    int n_checks = 0;
    int n_errors = 0;
    int fb[8][8];
    int rb[8][8];
    int qx[$];
    int qy[$];

    always #5 clk = ~clk;

    frac_search #(.SAD_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .filter_pix (filter_pix),
        .ref_pix    (ref_pix),
        .input_ready(input_ready),
        .mvx        (mvx),
        .mvy        (mvy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Exhaustive candidate search straight from the interpolation formula.
    task automatic model_best(output int bx, output int by);
        int best, s, p, d;
        best = -1;
        bx = 0;
        by = 0;
        for (int dy = 0; dy <= 4; dy += STEP) begin
            for (int dx = 0; dx <= 4; dx += STEP) begin
                s = 0;
                for (int r = 0; r < 7; r++) begin
                    for (int i = 0; i < 7; i++) begin
                        p = ((4-dx)*(4-dy)*rb[r][i] + dx*(4-dy)*rb[r][i+1]
                           + (4-dx)*dy*rb[r+1][i] + dx*dy*rb[r+1][i+1] + 8) / 16;
                        d = fb[r][i] - p;
                        s += (d < 0) ? -d : d;
                    end
                end
                if (best < 0 || s < best) begin
                    best = s;
                    bx = dx;
                    by = dy;
                end
            end
        end
    endtask

    function automatic logic [63:0] pack_f(input int r);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(fb[r][i]);
        return v;
    endfunction

    function automatic logic [63:0] pack_r(input int r);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(rb[r][i]);
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            input_ready = 1'b0;
        end
    endtask

    task automatic send_rows(input int n, input int st_lo, input int st_hi, input bit push);
        int bx, by, k;
        if (push) model_best(bx, by);
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            filter_pix  = pack_f(r);
            ref_pix     = pack_r(r);
            input_ready = 1'b1;
            if (push && r == 7) begin
                qx.push_back(bx);
                qy.push_back(by);
            end
            k = int'($urandom_range(st_hi, st_lo));
            idle(k);
        end
    endtask

    task automatic set_base();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) rb[r][i] = 16*i + 8*r;
    endtask

    task automatic mk_identity();
        set_base();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) fb[r][i] = rb[r][i];
    endtask

    task automatic mk_hshift();
        set_base();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) fb[r][i] = (i == 7) ? 0 : rb[r][i+1];
    endtask

    task automatic mk_offset(input int off);
        set_base();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) fb[r][i] = rb[r][i] + off;
    endtask

    task automatic mk_vshift();
        set_base();
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) fb[r][i] = (r == 7) ? 16*i + 64 : rb[r+1][i];
    endtask

    task automatic mk_random();
        int dx, dy, p, v;
        dx = int'($urandom_range(4, 0));
        dy = int'($urandom_range(4, 0));
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) rb[r][i] = int'($urandom_range(255, 0));
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                if (r == 7 || i == 7) begin
                    fb[r][i] = int'($urandom_range(255, 0));
                end else begin
                    p = ((4-dx)*(4-dy)*rb[r][i] + dx*(4-dy)*rb[r][i+1]
                       + (4-dx)*dy*rb[r+1][i] + dx*dy*rb[r+1][i+1] + 8) / 16;
                    v = p + int'($urandom_range(6, 0)) - 3;
                    fb[r][i] = (v < 0) ? 0 : (v > 255) ? 255 : v;
                end
            end
        end
    endtask

    // Monitor: tracks accepted rows at the interface and checks outputs #1 after every edge.
    initial begin
        int  cnt;
        bit  pend;
        int  cx, cy;
        cnt = 0;
        pend = 1'b0;
        cx = 0;
        cy = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                if (pend) begin
                    if (qx.size() == 0) begin
                        check("result_queue_nonempty", 0, 1);
                    end else begin
                        cx = qx.pop_front();
                        cy = qy.pop_front();
                    end
                end
                pend = 1'b0;
                if (input_ready) begin
                    if (cnt == 7) begin
                        cnt = 0;
                        pend = 1'b1;
                    end else begin
                        cnt++;
                    end
                end
            end
            #1;
            if (!reset) begin
                cnt = 0;
                pend = 1'b0;
                cx = 0;
                cy = 0;
            end
            check("mvx", int'(mvx), cx);
            check("mvy", int'(mvy), cy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        input_ready = 1'b0;
        filter_pix  = '0;
        ref_pix     = '0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle(3);

        mk_identity();  send_rows(8, 0, 0, 1'b1); idle(3);
        mk_hshift();    send_rows(8, 0, 0, 1'b1); idle(3);
        mk_offset(8);   send_rows(8, 0, 0, 1'b1); idle(3);
        mk_vshift();    send_rows(8, 0, 0, 1'b1); idle(3);
        mk_offset(2);   send_rows(8, 0, 0, 1'b1); idle(3);

        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++) begin
                rb[r][i] = 128;
                fb[r][i] = 128;
            end
        send_rows(8, 0, 0, 1'b1); idle(3);

        mk_identity();  send_rows(8, 0, 0, 1'b1);
        mk_hshift();    send_rows(8, 0, 0, 1'b1); idle(3);

        mk_hshift();    send_rows(8, 3, 3, 1'b1); idle(3);

        mk_identity();  send_rows(4, 0, 0, 1'b0);
        @(negedge clk);
        input_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(2);
        mk_vshift();    send_rows(8, 0, 0, 1'b1); idle(3);

        for (int b = 0; b < 24; b++) begin
            mk_random();
            if (b % 3 == 0) send_rows(8, 0, 0, 1'b1);
            else            send_rows(8, 0, 2, 1'b1);
        end
        idle(5);

        check("queue_drained", qx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
